// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t         - memory-wait FSM states (RUN, MEM_WAIT, ERROR)
//   FWD_*           - EX-stage ALU operand forwarding selects
//   RESULT_SRC_LOAD - ResultSrcE encoding that marks a load in execute
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// forward_unit: combinational forwarding select for one EX-stage operand.
// Ports:
//   i_rs_e        - source register of the operand in execute
//   i_rd_m        - destination register in memory
//   i_reg_write_m - register write enable in memory
//   i_rd_w        - destination register in writeback
//   i_reg_write_w - register write enable in writeback
//   o_fwd         - FWD_MEM / FWD_WB / FWD_RF
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_fwd
);

  // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
  always_comb begin
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs_e)) begin
      o_fwd = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs_e)) begin
      o_fwd = FWD_WB;
    end else begin
      o_fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
// Freezes the pipeline while data memory is not ready and latches a sticky
// error if the memory stays busy for MEM_TIMEOUT consecutive cycles.
// Optional build macro: HAZARD_PERF_EN enables saturating performance counters;
// without it the counter ports are tied to zero and no counter flops exist.
// Ports:
//   clk, rst                          - clock, async active-low reset
//   Rs1D, Rs2D                        - decode source registers
//   Rs1E, Rs2E, RdE, ResultSrcE       - execute fields
//   PCSrcE                            - taken branch/jump resolved in execute
//   RdM, RegWriteM, RdW, RegWriteW    - memory/writeback destinations
//   MemReqM, MemReadyM                - data-memory request and ready
//   StallF/D/E/M, FlushD/E/W          - stage register holds and clears
//   ForwardAE, ForwardBE              - ALU operand forwarding selects
//   MemErr                            - sticky data-memory timeout
//   LoadStallCnt, MemWaitCnt, FlushCnt - performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] LoadStallCnt,
  output logic [CNT_WIDTH-1:0] MemWaitCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt, w_next_wait_cnt;
  logic [1:0]        w_fwd_a, w_fwd_b;
  logic              w_lw_stall, w_mem_hold, w_freeze;

  forward_unit u_fwd_a (
    .i_rs_e        (Rs1E),
    .i_rd_m        (RdM),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RdW),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  forward_unit u_fwd_b (
    .i_rs_e        (Rs2E),
    .i_rd_m        (RdM),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RdW),
    .i_reg_write_w (RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  // Outputs are gated by rst so an asserted reset silences the pipeline controls
  // even though the stage inputs may still show a pending hazard.
  assign ForwardAE = rst ? w_fwd_a : FWD_RF;
  assign ForwardBE = rst ? w_fwd_b : FWD_RF;

  assign w_lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_mem_hold = MemReqM && !MemReadyM;
  assign w_freeze   = w_mem_hold || (r_state == ERROR);
  assign MemErr     = (r_state == ERROR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // NOTE: every signal driven here gets a default first, otherwise paths that
  // skip an assignment would infer latches.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (w_mem_hold) begin
          w_next_state    = MEM_WAIT;
          w_next_wait_cnt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request is treated like an ack: the wait is over.
        if (!w_mem_hold) begin
          w_next_state    = RUN;
          w_next_wait_cnt = '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = ERROR;
        end else begin
          w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        w_next_state = ERROR;
      end
      default: begin
        w_next_state    = RUN;
        w_next_wait_cnt = '0;
      end
    endcase
  end

  // Freeze beats branch, branch beats load-use: a branch discards the D-stage
  // instruction, so its load-use dependency no longer matters.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      if (w_freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic w_cnt_load, w_cnt_mem, w_cnt_flush;

  assign w_cnt_load  = rst && !w_freeze && !PCSrcE && w_lw_stall;
  assign w_cnt_mem   = rst && w_mem_hold;
  assign w_cnt_flush = rst && !w_freeze && PCSrcE;

  // NOTE: the counters are plain flops, not a memory, so they take the async
  // reset like the rest of the control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LoadStallCnt <= '0;
      MemWaitCnt   <= '0;
      FlushCnt     <= '0;
    end else begin
      if (w_cnt_load  && (LoadStallCnt != '1)) LoadStallCnt <= LoadStallCnt + 1'b1;
      if (w_cnt_mem   && (MemWaitCnt   != '1)) MemWaitCnt   <= MemWaitCnt + 1'b1;
      if (w_cnt_flush && (FlushCnt     != '1)) FlushCnt     <= FlushCnt + 1'b1;
    end
  end
`else
  assign LoadStallCnt = '0;
  assign MemWaitCnt   = '0;
  assign FlushCnt     = '0;
`endif

endmodule
